// File: rtl/tpg_vid_axis_pkg.sv
// Shared types and constants for the test-pattern video to AXI4-Stream bridge.
// FIFO entry layout is {rgb, eol, sof} with the flag bits at the bottom.
package tpg_vid_axis_pkg;

    localparam int DEF_B          = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_CNT_W      = 16;

    localparam int SOF_BIT  = 0;
    localparam int EOL_BIT  = 1;
    localparam int DATA_LSB = 2;

    typedef enum logic [1:0] {
        SYNC,
        ARMED,
        ACTIVE,
        DROP
    } state_e;

    function automatic int entry_w(input int b);
        return 3 * b + DATA_LSB;
    endfunction

endpackage

// File: rtl/tpg_vid_axis_if.sv
// AXI4-Stream video bus: tdata = {red, green, blue}, tuser = SOF, tlast = EOL.
// B must match the B of the module driving the master side.
interface tpg_vid_axis_if #(
    parameter int B = tpg_vid_axis_pkg::DEF_B
) ();

    logic [3*B-1:0] tdata;
    logic           tvalid;
    logic           tready;
    logic           tuser;
    logic           tlast;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/tpg_vid_axis_fifo.sv
// Synchronous FIFO with first-word-fall-through registered output stage.
// Holds DEPTH entries in the array plus one in the output register.
module tpg_vid_axis_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      resetb_i,
    input  logic                      wr_en_i,
    input  logic [W-1:0]              wr_data_i,
    input  logic                      rd_en_i,
    output logic [W-1:0]              rd_data_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH)+1:0]  level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          out_valid_q;
    logic [W-1:0]  out_data_q;

    logic pop;
    logic load;
    logic mem_empty;
    logic mem_rd;
    logic mem_wr;
    logic bypass;

    assign pop       = out_valid_q & rd_en_i;
    assign load      = ~out_valid_q | pop;
    assign mem_empty = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign mem_rd    = load & ~mem_empty;
    // An empty array feeds an idle output register directly, giving one-cycle latency.
    assign bypass    = load & mem_empty & wr_en_i;
    assign mem_wr    = wr_en_i & ~bypass & (~full_o | mem_rd);

    // NOTE: storage array has no reset; only pointers and the count define contents.
    always_ff @(posedge clk_i) begin
        if (mem_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (mem_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (mem_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(mem_wr) - (AW+1)'(mem_rd);
            if (load) begin
                out_valid_q <= mem_rd | bypass;
                if (mem_rd) begin
                    out_data_q <= mem_q[rd_ptr_q];
                end else if (bypass) begin
                    out_data_q <= wr_data_i;
                end
            end
        end
    end

    assign rd_data_o = out_data_q;
    assign empty_o   = ~out_valid_q;
    assign level_o   = (AW+2)'(cnt_q) + (AW+2)'(out_valid_q);

endmodule

// File: rtl/tpg_vid_to_axis.sv
// Parallel RGB + DE/FV video to AXI4-Stream with SOF/EOL marking and overflow reporting.
// Optional line-length checker enabled by defining TPG_VID_AXIS_LINE_CHECK_EN.
module tpg_vid_to_axis
    import tpg_vid_axis_pkg::*;
#(
    parameter int B          = DEF_B,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             resetb_i,
    input  logic             de_i,
    input  logic             fv_i,
    input  logic [B-1:0]     red_i,
    input  logic [B-1:0]     green_i,
    input  logic [B-1:0]     blue_i,
    input  logic [CNT_W-1:0] hres_i,
    tpg_vid_axis_if.master   m_axis,
    output logic             overflow_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic             line_err_o
);

    localparam int EW = entry_w(B);

    state_e state_q, state_d;

    logic             fv_q, de_q;
    logic             fv_rise, de_fall;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] hres_q;
    logic             sof_pend_q;
    logic             overflow_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic             push_req, push, ovf_ev, arm, eol, pop;
    logic             fifo_full, fifo_empty;
    logic [EW-1:0]    wr_data, rd_data;
    logic [$clog2(FIFO_DEPTH)+1:0] unused_fifo_level;

    assign fv_rise = fv_i & ~fv_q;
    assign de_fall = de_q & ~de_i;
    assign pop     = m_axis.tvalid & m_axis.tready;
    assign eol     = (x_q == hres_q - CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) state_q <= SYNC;
        else           state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            SYNC:    if (!fv_i) state_d = ARMED;
            ARMED:   if (fv_rise) state_d = (hres_i == '0) ? SYNC : ACTIVE;
            ACTIVE:  if (!fv_i) state_d = ARMED;
                     else if (ovf_ev) state_d = DROP;
            DROP:    if (!fv_i) state_d = ARMED;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        push_req = 1'b0;
        arm      = 1'b0;
        case (state_q)
            ACTIVE:  push_req = de_i & fv_i;
            ARMED:   arm      = fv_rise & (hres_i != '0);
            default: ;
        endcase
        // A pop in the same cycle frees a slot, so only an unserviced full FIFO overflows.
        ovf_ev = push_req & fifo_full & ~pop;
        push   = push_req & ~ovf_ev;
    end

    always_comb begin
        x_d = x_q;
        if (arm || de_fall) x_d = '0;
        else if (push)      x_d = eol ? '0 : x_q + CNT_W'(1);
    end

    always_comb begin
        wr_data                     = '0;
        wr_data[DATA_LSB +: 3*B]    = {red_i, green_i, blue_i};
        wr_data[SOF_BIT]            = sof_pend_q;
        wr_data[EOL_BIT]            = eol;
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fv_q        <= 1'b0;
            de_q        <= 1'b0;
            x_q         <= '0;
            hres_q      <= '0;
            sof_pend_q  <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            fv_q <= fv_i;
            de_q <= de_i;
            x_q  <= x_d;
            if (arm) hres_q <= hres_i;
            if (arm)       sof_pend_q <= 1'b1;
            else if (push) sof_pend_q <= 1'b0;
            if (ovf_ev) overflow_q <= 1'b1;
            if (push && sof_pend_q) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
    end

`ifdef TPG_VID_AXIS_LINE_CHECK_EN
    logic eol_q;
    logic line_err_q;

    // Flags lines that end before the eol pixel or run on past it.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            eol_q      <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            eol_q <= push & eol;
            if ((state_q == ACTIVE) &&
                ((de_fall && (x_q != '0)) || (eol_q && de_i && fv_i))) begin
                line_err_q <= 1'b1;
            end
        end
    end

    assign line_err_o = line_err_q;
`else
    assign line_err_o = 1'b0;
`endif

    tpg_vid_axis_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .resetb_i  (resetb_i),
        .wr_en_i   (push),
        .wr_data_i (wr_data),
        .rd_en_i   (m_axis.tready),
        .rd_data_o (rd_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .level_o   (unused_fifo_level)
    );

    assign m_axis.tvalid = ~fifo_empty;
    assign m_axis.tdata  = rd_data[DATA_LSB +: 3*B];
    assign m_axis.tuser  = rd_data[SOF_BIT];
    assign m_axis.tlast  = rd_data[EOL_BIT];

    assign overflow_o  = overflow_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_tpg_vid_to_axis.sv
// Directed bench for tpg_vid_to_axis: scoreboarded beats, AXI hold rule, status outputs.
// Pixel data is a running 24-bit sequence so order and content are checked together.
module tb_tpg_vid_to_axis;

    logic        clk = 1'b0;
    logic        resetb;
    logic        de, fv;
    logic [7:0]  red, green, blue;
    logic [15:0] hres;
    logic        overflow;
    logic [15:0] frame_cnt;
    logic        line_err;

    tpg_vid_axis_if #(.B(8)) axis ();

    tpg_vid_to_axis #(
        .B          (8),
        .FIFO_DEPTH (16),
        .CNT_W      (16)
    ) dut (
        .clk_i       (clk),
        .resetb_i    (resetb),
        .de_i        (de),
        .fv_i        (fv),
        .red_i       (red),
        .green_i     (green),
        .blue_i      (blue),
        .hres_i      (hres),
        .m_axis      (axis),
        .overflow_o  (overflow),
        .frame_cnt_o (frame_cnt),
        .line_err_o  (line_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] data;
        logic        user;
        logic        last;
    } beat_t;

    beat_t       exp_q [$];
    logic [23:0] pix_seq = '0;
    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          beat_cnt = 0;
    int          user_cnt = 0;
    int          last_cnt = 0;
    int          ign_cnt = 0;
    bit          mon_en = 1'b1;
    bit          stall_pend = 1'b0;
    logic [25:0] held;
    bit          t4_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Beat monitor: scoreboard compare plus hold-while-stalled rule.
    always @(negedge clk) begin
        if (!resetb) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend)
                check("hold", {axis.tvalid, axis.tdata, axis.tuser, axis.tlast}, {1'b1, held});
            if (axis.tvalid && axis.tready) begin
                if (mon_en) begin
                    beat_cnt++;
                    if (axis.tuser) user_cnt++;
                    if (axis.tlast) last_cnt++;
                    if (exp_q.size() == 0) begin
                        check("extra_beat", exp_q.size(), 1);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("beat", {axis.tdata, axis.tuser, axis.tlast}, e);
                    end
                end else begin
                    ign_cnt++;
                end
            end
            stall_pend = axis.tvalid && !axis.tready;
            held = {axis.tdata, axis.tuser, axis.tlast};
        end
    end

    task automatic drive_line(input int n, input int hres_v, input bit enq, input bit sof_line);
        for (int x = 0; x < n; x++) begin
            beat_t e;
            de = 1'b1;
            {red, green, blue} = pix_seq;
            if (enq) begin
                e.data = pix_seq;
                e.user = sof_line && (x == 0);
                e.last = (x == hres_v - 1);
                exp_q.push_back(e);
            end
            pix_seq++;
            tick();
        end
        de = 1'b0;
    endtask

    // Lead-in has a stray DE pulse with FV low, which must be ignored.
    task automatic drive_frame(input int lines, input int ppl, input int short_idx,
                               input int hres_v, input int blank, input bit enq);
        fv = 1'b0; de = 1'b0; hres = 16'(hres_v);
        tick();
        de = 1'b1; {red, green, blue} = 24'hABCDEF;
        tick(); tick();
        de = 1'b0;
        tick(); tick();
        fv = 1'b1;
        tick(); tick();
        for (int l = 0; l < lines; l++) begin
            drive_line((l == short_idx) ? ppl - 1 : ppl, hres_v, enq, l == 0);
            repeat (blank) tick();
        end
        fv = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 4000 && exp_q.size() != 0; n++) tick();
        repeat (4) tick();
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 2000 && axis.tvalid; n++) tick();
        check(tag, axis.tvalid, 0);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_tvalid"},    axis.tvalid, 0);
        check({pfx, "_tdata"},     axis.tdata,  0);
        check({pfx, "_tuser"},     axis.tuser,  0);
        check({pfx, "_tlast"},     axis.tlast,  0);
        check({pfx, "_overflow"},  overflow,    0);
        check({pfx, "_frame_cnt"}, frame_cnt,   0);
        check({pfx, "_line_err"},  line_err,    0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, u0, l0, i0;
        resetb = 1'b0; de = 1'b0; fv = 1'b0;
        red = '0; green = '0; blue = '0; hres = '0;
        axis.tready = 1'b1;
        repeat (3) tick();
        check_reset_state("rst");
        resetb = 1'b1;
        tick();

        // Full-width frame, reduced line count, continuous ready.
        b0 = beat_cnt; u0 = user_cnt; l0 = last_cnt;
        drive_frame(8, 640, -1, 640, 16, 1'b1);
        wait_drain("t1_drain");
        check("t1_beats",     beat_cnt - b0, 5120);
        check("t1_tuser_cnt", user_cnt - u0, 1);
        check("t1_tlast_cnt", last_cnt - l0, 8);
        check("t1_frame_cnt", frame_cnt, 1);

        // Ready toggling every cycle, 8 px lines with 8 px blanking.
        l0 = last_cnt;
        t4_done = 1'b0;
        fork
            begin
                drive_frame(4, 8, -1, 8, 8, 1'b1);
                wait_drain("t4_drain");
                t4_done = 1'b1;
            end
            begin
                for (int i = 0; i < 20000 && !t4_done; i++) begin
                    axis.tready = !axis.tready;
                    tick();
                end
            end
        join
        axis.tready = 1'b1;
        check("t4_overflow",  overflow, 0);
        check("t4_frame_cnt", frame_cnt, 2);
        check("t4_tlast_cnt", last_cnt - l0, 4);

        // Latched hres of zero: whole frame ignored.
        b0 = beat_cnt;
        drive_frame(2, 8, -1, 0, 4, 1'b0);
        repeat (10) tick();
        check("t6_beats",     beat_cnt - b0, 0);
        check("t6_frame_cnt", frame_cnt, 2);

        // Short middle line: 15 px with hres 16, next line resynchronised.
        l0 = last_cnt;
        drive_frame(3, 16, 1, 16, 6, 1'b1);
        wait_drain("t5_drain");
        check("t5_tlast_cnt", last_cnt - l0, 2);
        check("t5_frame_cnt", frame_cnt, 3);
`ifdef TPG_VID_AXIS_LINE_CHECK_EN
        check("t5_line_err", line_err, 1);
`else
        check("t5_line_err", line_err, 0);
`endif

        // Reset asserted with queued pixels, released while FV is high.
        axis.tready = 1'b0;
        hres = 16'd16; fv = 1'b0;
        tick(); tick();
        fv = 1'b1;
        tick(); tick();
        drive_line(5, 16, 1'b0, 1'b1);
        tick();
        check("t2_pre_tvalid", axis.tvalid, 1);
        resetb = 1'b0;
        #2;
        check_reset_state("t2_rst");
        tick(); tick();
        axis.tready = 1'b1;
        resetb = 1'b1;
        tick();
        for (int l = 0; l < 2; l++) begin
            drive_line(16, 16, 1'b0, 1'b0);
            repeat (4) tick();
        end
        check("t2_mid_tvalid", axis.tvalid, 0);
        u0 = user_cnt;
        drive_frame(3, 16, -1, 16, 6, 1'b1);
        wait_drain("t2_drain");
        check("t2_tuser_cnt", user_cnt - u0, 1);
        check("t2_frame_cnt", frame_cnt, 1);
        check("t2_line_err",  line_err, 0);

        // 40-cycle stall mid-line overflows the FIFO; rest of frame dropped.
        mon_en = 1'b0;
        i0 = ign_cnt;
        fork
            drive_frame(2, 64, -1, 64, 8, 1'b0);
            begin
                repeat (20) tick();
                axis.tready = 1'b0;
                repeat (40) tick();
                axis.tready = 1'b1;
            end
        join
        wait_idle("t3_idle");
        check("t3_overflow",  overflow, 1);
        check("t3_frame_cnt", frame_cnt, 2);
        check("t3_dropped",   (ign_cnt - i0) < 128, 1);
        mon_en = 1'b1;
        b0 = beat_cnt; u0 = user_cnt;
        drive_frame(2, 64, -1, 64, 8, 1'b1);
        wait_drain("t3_next_drain");
        check("t3_next_beats",     beat_cnt - b0, 128);
        check("t3_next_tuser_cnt", user_cnt - u0, 1);
        check("t3_next_frame_cnt", frame_cnt, 3);
        check("t3_overflow_stick", overflow, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
